// File: rtl/cst_gen_lanes.sv
// Round-constant generator: NLANES chained GF(2) xtime stages per beat over a W-bit state.
// Optional inverse stepping (xi instead of xt) is compiled in with CST_GEN_INVERSE_EN.

module cst_xt_stage #(
    parameter int unsigned    W    = 32,
    parameter logic [W-1:0]   POLY = 32'h00000101
) (
`ifdef CST_GEN_INVERSE_EN
    input  logic         dir,
`endif
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);
    logic [W-1:0] fwd;

    assign fwd = {x[W-2:0], 1'b0} ^ (x[W-1] ? POLY : '0);

`ifdef CST_GEN_INVERSE_EN
    logic [W-1:0] xp, inv;

    // Inverse of xt: undo the feedback (POLY[0]=1 marks it) then shift the MSB back in.
    assign xp  = x ^ POLY;
    assign inv = x[0] ? {1'b1, xp[W-1:1]} : {1'b0, x[W-1:1]};
    assign y   = dir ? inv : fwd;
`else
    assign y   = fwd;
`endif
endmodule

module cst_gen_lanes #(
    parameter int unsigned  W      = 32,
    parameter int unsigned  NLANES = 4,
    parameter int unsigned  NSTEPS = 12,
    parameter logic [W-1:0] POLY   = 32'h00000101,
    localparam int unsigned SW     = $clog2(NSTEPS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [W-1:0]        seed_i,
`ifdef CST_GEN_INVERSE_EN
    input  logic                dir_i,
`endif
    output logic [NLANES*W-1:0] cst_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [SW-1:0]       step_o
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t                    state_q, state_d;
    logic [W-1:0]              base_q;
    logic [SW-1:0]             step_q;
    logic                      done_q;
    logic                      hs, last;
    logic [NLANES:0][W-1:0]    lane;

`ifdef CST_GEN_INVERSE_EN
    logic                      dir_q;
`endif

    assign hs   = (state_q == RUN) && ready_i;
    assign last = (step_q == SW'(NSTEPS - 1));

    // lane[NLANES] is one stage past the last lane: the next beat's base.
    assign lane[0] = base_q;
    for (genvar k = 0; k < NLANES; k++) begin : g_lane
        cst_xt_stage #(.W(W), .POLY(POLY)) u_stage (
`ifdef CST_GEN_INVERSE_EN
            .dir (dir_q),
`endif
            .x   (lane[k]),
            .y   (lane[k+1])
        );
        assign cst_o[k*W +: W] = lane[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i)   state_d = RUN;
            RUN:     if (hs && last) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_o = 1'b0;
        busy_o  = 1'b0;
        if (state_q == RUN) begin
            valid_o = 1'b1;
            busy_o  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
            step_q <= '0;
            done_q <= 1'b0;
`ifdef CST_GEN_INVERSE_EN
            dir_q  <= 1'b0;
`endif
        end else begin
            done_q <= hs && last;
            if (state_q == IDLE) begin
                step_q <= '0;
                if (start_i) begin
                    base_q <= seed_i;
`ifdef CST_GEN_INVERSE_EN
                    dir_q  <= dir_i;
`endif
                end
            end else if (hs) begin
                if (last) begin
                    base_q <= '0;
                    step_q <= '0;
                end else begin
                    base_q <= lane[NLANES];
                    step_q <= step_q + SW'(1);
                end
            end
        end
    end

    assign done_o = done_q;
    assign step_o = step_q;
endmodule

// File: tb/tb_cst_gen_lanes.sv
// Directed bench: a 1-lane/4-step instance and a 4-lane/3-step instance on a shared clock and reset.

module tb_cst_gen_lanes;
    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic         start1 = 1'b0, ready1 = 1'b0;
    logic [31:0]  seed1  = '0;
    logic [31:0]  cst1;
    logic         valid1, busy1, done1;
    logic [2:0]   step1;

    logic         start4 = 1'b0, ready4 = 1'b0;
    logic [31:0]  seed4  = '0;
    logic [127:0] cst4;
    logic         valid4, busy4, done4;
    logic [1:0]   step4;

`ifdef CST_GEN_INVERSE_EN
    logic         dir1 = 1'b0, dir4 = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cst_gen_lanes #(.W(32), .NLANES(1), .NSTEPS(4), .POLY(32'h00000101)) dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .seed_i(seed1),
`ifdef CST_GEN_INVERSE_EN
        .dir_i(dir1),
`endif
        .cst_o(cst1), .valid_o(valid1), .ready_i(ready1),
        .busy_o(busy1), .done_o(done1), .step_o(step1)
    );

    cst_gen_lanes #(.W(32), .NLANES(4), .NSTEPS(3), .POLY(32'h00000101)) dut4 (
        .clk(clk), .rst(rst), .start_i(start4), .seed_i(seed4),
`ifdef CST_GEN_INVERSE_EN
        .dir_i(dir4),
`endif
        .cst_o(cst4), .valid_o(valid4), .ready_i(ready4),
        .busy_o(busy4), .done_o(done4), .step_o(step4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packs {cst, valid, busy, step, done} of dut1 into one compared word.
    task automatic chk1(input string tag, input logic [31:0] cst, input logic vld,
                        input logic [2:0] stp, input logic dn);
        chk(tag, {cst1, valid1, busy1, step1, done1}, {cst, vld, vld, stp, dn});
    endtask

    initial begin
        // Reset
        tick(); tick();
        chk1("reset1", 32'h0, 1'b0, 3'd0, 1'b0);
        chk("reset4", {cst4, valid4, busy4, step4, done4}, '0);
        rst = 1'b0;
        tick();
        chk1("idle", 32'h0, 1'b0, 3'd0, 1'b0);

        // Seed 1, ready always high: 1,2,4,8 then done pulse
        ready1 = 1'b1; seed1 = 32'h1; start1 = 1'b1;
        tick(); start1 = 1'b0;
        chk1("t1_b0", 32'h1, 1'b1, 3'd0, 1'b0);
        tick(); chk1("t1_b1", 32'h2, 1'b1, 3'd1, 1'b0);
        tick(); chk1("t1_b2", 32'h4, 1'b1, 3'd2, 1'b0);
        tick(); chk1("t1_b3", 32'h8, 1'b1, 3'd3, 1'b0);
        tick(); chk1("t1_done", 32'h0, 1'b0, 3'd0, 1'b1);
        tick(); chk1("t1_after", 32'h0, 1'b0, 3'd0, 1'b0);

        // MSB feedback on both instances
        seed1 = 32'h80000000; start1 = 1'b1;
        seed4 = 32'h80000000; start4 = 1'b1; ready4 = 1'b1;
        tick(); start1 = 1'b0; start4 = 1'b0;
        chk1("t2_b0", 32'h80000000, 1'b1, 3'd0, 1'b0);
        chk("t4_b0", cst4, {32'h00000404, 32'h00000202, 32'h00000101, 32'h80000000});
        chk("t4_b0_ctl", {valid4, busy4, step4, done4}, {1'b1, 1'b1, 2'd0, 1'b0});
        tick();
        chk1("t2_b1", 32'h00000101, 1'b1, 3'd1, 1'b0);
        chk("t4_b1", cst4, {32'h00004040, 32'h00002020, 32'h00001010, 32'h00000808});
        tick();
        chk1("t2_b2", 32'h00000202, 1'b1, 3'd2, 1'b0);
        chk("t4_b2", cst4, {32'h00040400, 32'h00020200, 32'h00010100, 32'h00008080});
        tick();
        chk1("t2_b3", 32'h00000404, 1'b1, 3'd3, 1'b0);
        chk("t4_done", {cst4, valid4, busy4, step4, done4}, {128'h0, 1'b0, 1'b0, 2'd0, 1'b1});
        tick();
        chk1("t2_done", 32'h0, 1'b0, 3'd0, 1'b1);

        // Zero seed is legal: all-zero lanes while valid
        seed4 = 32'h0; start4 = 1'b1;
        tick(); start4 = 1'b0;
        chk("t4_zero", {cst4, valid4, step4}, {128'h0, 1'b1, 2'd0});
        ready4 = 1'b0;

        // Back-pressure: ready 0,0,1,0,1
        seed1 = 32'h3; start1 = 1'b1; ready1 = 1'b0;
        tick(); start1 = 1'b0;
        chk1("bp_b0", 32'h3, 1'b1, 3'd0, 1'b0);
        tick(); chk1("bp_hold0a", 32'h3, 1'b1, 3'd0, 1'b0);
        tick(); chk1("bp_hold0b", 32'h3, 1'b1, 3'd0, 1'b0);
        ready1 = 1'b1;
        tick(); chk1("bp_b1", 32'h6, 1'b1, 3'd1, 1'b0);
        ready1 = 1'b0;
        tick(); chk1("bp_hold1", 32'h6, 1'b1, 3'd1, 1'b0);
        ready1 = 1'b1;
        tick(); chk1("bp_b2", 32'hC, 1'b1, 3'd2, 1'b0);
        tick(); chk1("bp_b3", 32'h18, 1'b1, 3'd3, 1'b0);
        tick(); chk1("bp_done", 32'h0, 1'b0, 3'd0, 1'b1);
        tick(); chk1("bp_after", 32'h0, 1'b0, 3'd0, 1'b0);

        // Asynchronous reset at step 2
        seed1 = 32'h5; start1 = 1'b1;
        tick(); start1 = 1'b0;
        tick(); tick();
        chk1("rs_b2", 32'h14, 1'b1, 3'd2, 1'b0);
        rst = 1'b1;
        #1;
        chk1("rs_async", 32'h0, 1'b0, 3'd0, 1'b0);
        tick(); rst = 1'b0;
        tick(); chk1("rs_nodone", 32'h0, 1'b0, 3'd0, 1'b0);

        // Restart; start held through the run and on the last handshake is ignored
        seed1 = 32'h7; start1 = 1'b1;
        tick(); seed1 = 32'hFF;
        chk1("st_b0", 32'h7, 1'b1, 3'd0, 1'b0);
        tick(); chk1("st_b1", 32'hE, 1'b1, 3'd1, 1'b0);
        tick(); chk1("st_b2", 32'h1C, 1'b1, 3'd2, 1'b0);
        tick(); chk1("st_b3", 32'h38, 1'b1, 3'd3, 1'b0);
        seed1 = 32'h9;
        tick(); chk1("st_done", 32'h0, 1'b0, 3'd0, 1'b1);
        tick(); start1 = 1'b0;
        chk1("bb_b0", 32'h9, 1'b1, 3'd0, 1'b0);
        tick(); chk1("bb_b1", 32'h12, 1'b1, 3'd1, 1'b0);
        tick(); tick();
        chk1("bb_b3", 32'h48, 1'b1, 3'd3, 1'b0);
        tick(); chk1("bb_done", 32'h0, 1'b0, 3'd0, 1'b1);

`ifdef CST_GEN_INVERSE_EN
        // Inverse stepping
        dir1 = 1'b1; seed1 = 32'h00000101; start1 = 1'b1;
        tick(); start1 = 1'b0; dir1 = 1'b0;
        chk1("inv_b0", 32'h00000101, 1'b1, 3'd0, 1'b0);
        tick(); chk1("inv_b1", 32'h80000000, 1'b1, 3'd1, 1'b0);
        tick(); chk1("inv_b2", 32'h40000000, 1'b1, 3'd2, 1'b0);
        tick(); chk1("inv_b3", 32'h20000000, 1'b1, 3'd3, 1'b0);
        tick(); chk1("inv_done", 32'h0, 1'b0, 3'd0, 1'b1);

        // Inverse run seeded with 0x88 (last forward beat of seed 0x11) walks back
        dir1 = 1'b1; seed1 = 32'h88; start1 = 1'b1;
        tick(); start1 = 1'b0; dir1 = 1'b0;
        chk1("rev_b0", 32'h88, 1'b1, 3'd0, 1'b0);
        tick(); chk1("rev_b1", 32'h44, 1'b1, 3'd1, 1'b0);
        tick(); chk1("rev_b2", 32'h22, 1'b1, 3'd2, 1'b0);
        tick(); chk1("rev_b3", 32'h11, 1'b1, 3'd3, 1'b0);
        tick(); chk1("rev_done", 32'h0, 1'b0, 3'd0, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cst_gen_lanes.md
Name: cst_gen_lanes

Overview:
- Sequential round-constant generator for the Shadow-512 permutation and related masked datapaths.
- Iterates a parametrised GF(2)-polynomial xtime (multiply by x modulo POLY) over a W-bit state.
- Presents NLANES consecutive constants per beat on a valid/ready stream, for NSTEPS beats per run, then signals completion.
- Replaces a fixed 32-bit single-step combinational constant multiplier in the round-control path.

Parameters:
- W, 32, constant width in bits (W >= 8).
- NLANES, 4, constants produced per beat (>= 1).
- NSTEPS, 12, beats per run (>= 1).
- POLY, 32'h00000101, feedback mask XORed in when the shifted-out MSB is 1; POLY[0] must be 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start_i  input  1  run request; sampled only in IDLE.
- seed_i  input  W  initial state; captured with start_i.
- cst_o  output  NLANES*W  lane k at bits [k*W +: W].
- valid_o  output  1  cst_o holds a valid beat.
- ready_i  input  1  consumer accepts the beat.
- busy_o  output  1  high in RUN.
- done_o  output  1  one-cycle pulse after the last beat is accepted.
- step_o  output  clog2(NSTEPS+1)  index of the current beat.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: state IDLE, base=0, step=0. All outputs are 0: cst_o, valid_o, busy_o, done_o, step_o.
- xt(x) = ((x<<1) mod 2^W) ^ (x[W-1] ? POLY : 0). With the defaults this equals (x<<1) ^ b ^ (b<<8) for b = x>>31.
- Lanes:
  - lane0 = base, lane k = xt^k(base).
  - cst_o is combinational from the base register: a chain of NLANES xt stages.
  - No registered output latency.
- IDLE:
  - On start_i=1: base <= seed_i, step <= 0, go to RUN.
  - valid_o, busy_o and step_o are low/0. base is held at 0, so cst_o=0.
- RUN:
  - valid_o=1 and busy_o=1.
  - On valid_o & ready_i: base <= xt^NLANES(base) and step <= step+1.
  - If step == NSTEPS-1 at that handshake: go to IDLE, base <= 0, step <= 0, done_o=1 in the next cycle only.
  - While ready_i=0, base, step and cst_o hold stable. No beat is dropped or repeated.
- Start latency: the first beat is valid in the cycle after the start_i edge is sampled.
- start_i while in RUN is ignored, including a start coinciding with the last handshake.
- start_i in the done_o cycle (state IDLE) is accepted normally, so runs can be back-to-back with one idle cycle.
- seed_i=0 yields all-zero constants for the whole run. This is legal; no special case.
- Asynchronous reset mid-run: immediately returns to the reset values. A pending beat is lost and done_o is not generated.
- All arithmetic is modulo 2^W.
- step_o counts 0..NSTEPS-1 in RUN.

Optional Feature:
- CST_GEN_INVERSE_EN defined:
  - Adds input dir_i (1 bit), sampled with start_i and held for the run.
  - dir_i=1 replaces xt with its inverse: xi(x) = x[0] ? (((x ^ POLY) >> 1) | 2^(W-1)) : (x >> 1).
  - In that mode lane k = xi^k(base) and the advance uses xi^NLANES. This produces the constant sequence in reverse for inverse rounds.
- CST_GEN_INVERSE_EN not defined: no dir_i port and forward-only behaviour. Area must equal the forward-only logic.

Test Plan:
- W=32, NLANES=1, NSTEPS=4, seed 0x00000001, ready_i=1 -> beats 0x1, 0x2, 0x4, 0x8 on consecutive cycles; done_o pulses one cycle after the 4th beat; step_o goes 0,1,2,3.
- NLANES=1, seed 0x80000000 -> beat0=0x80000000, beat1=0x00000101. NLANES=4, same seed -> lanes 0x80000000, 0x00000101, 0x00000202, 0x00000404; next beat lane0=0x00000808.
- ready_i toggled 0,0,1,0,1 during RUN -> cst_o and step_o stable while ready_i=0; exactly NSTEPS distinct beats; done_o single pulse.
- rst asserted at step 2 -> all outputs 0 immediately, no done_o; a new start_i after release restarts from the new seed.
- start_i pulsed mid-run and on the last handshake -> ignored. start_i in the done_o cycle -> new run; first beat one cycle later.
- With CST_GEN_INVERSE_EN, dir_i=1, seed 0x00000101, NLANES=1 -> beats 0x00000101, 0x80000000, 0x40000000. A forward run followed by an inverse run seeded with the last forward value reproduces the forward sequence reversed.
